// File: rtl/mech_drive_sum_pkg.sv
// Shared constants and helpers for the multi-cavity mechanical drive summer:
// frame length derivation, clog2 and the signed saturation helpers.
package mech_drive_sum_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // One frame visits every mechanical mode twice (real and imaginary slot).
    function automatic int n_cycles_of(input int n_mech_modes);
        return 2 * n_mech_modes;
    endfunction

    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat64(input logic signed [63:0] value, input int w);
        if (value > sat_hi(w)) return sat_hi(w);
        if (value < sat_lo(w)) return sat_lo(w);
        return value;
    endfunction

    function automatic logic clipped64(input logic signed [63:0] value, input int w);
        return (value > sat_hi(w)) || (value < sat_lo(w));
    endfunction

endpackage

// File: rtl/mech_drive_sum_if.sv
// Bundle of the per-cycle sample inputs and status/drive outputs of mech_drive_sum.
interface mech_drive_sum_if #(
    parameter int n_cav = 2,
    parameter int dw    = 18,
    parameter int ew    = 12
);
    logic [n_cav*dw-1:0] cav_eig_drive;
    logic [dw-1:0]       piezo_eig_drive;
    logic [dw-1:0]       noise_eig_drive;
    logic [31:0]         rnd;
    logic                clip_clear;

    logic                start;
    logic                start_outer;
    logic                start_eig;
    logic [ew-1:0]       environment;
    logic [dw-1:0]       eig_drive;
    logic                edrive_clip;
    logic                clip_sticky;
    logic [15:0]         clip_count;

    modport master (
        output cav_eig_drive, piezo_eig_drive, noise_eig_drive, rnd, clip_clear,
        input  start, start_outer, start_eig, environment, eig_drive,
               edrive_clip, clip_sticky, clip_count
    );

    modport slave (
        input  cav_eig_drive, piezo_eig_drive, noise_eig_drive, rnd, clip_clear,
        output start, start_outer, start_eig, environment, eig_drive,
               edrive_clip, clip_sticky, clip_count
    );
endinterface

// File: rtl/mech_noise_cic.sv
// White-noise environment term: a wrapping random-walk accumulator that is
// differenced once per frame, giving a zero-mean per-frame increment.
module mech_noise_cic
    import mech_drive_sum_pkg::*;
#(
    parameter int noise_bits = 3,
    parameter int ew         = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   rnd,
    input  logic          start_eig,
    output logic [ew-1:0] environment
);
    logic [ew-1:0] acc_reg;
    logic [ew-1:0] n1_reg;
    logic [ew-1:0] env_reg;
    logic [ew-1:0] u1;
    logic [ew-1:0] u2;

    assign u1 = ew'(rnd[noise_bits-1:0]);
    assign u2 = ew'(rnd[2*noise_bits-1:noise_bits]);

    if (2 * noise_bits < 32) begin : g_spare_rnd
        logic unused_rnd;
        assign unused_rnd = &{1'b0, rnd[31:2*noise_bits]};
    end

    // Previous snapshot minus current: a positive u1 bias gives a negative term.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
            n1_reg  <= '0;
            env_reg <= '0;
        end else begin
            acc_reg <= acc_reg + u1 - u2;
            if (start_eig) begin
                n1_reg  <= acc_reg;
                env_reg <= n1_reg - acc_reg;
            end
        end
    end

    assign environment = env_reg;
endmodule

// File: rtl/mech_drive_sum.sv
// Frame timing, noise environment and saturated sum of all cavity, piezo and
// noise eigenmode drives into the single shared mechanical resonator drive.
module mech_drive_sum
    import mech_drive_sum_pkg::*;
#(
    parameter int n_cav        = 2,
    parameter int n_mech_modes = 7,
    parameter int dw           = 18,
    parameter int noise_bits   = 3,
    parameter int ew           = 12
) (
    input  logic            clk,
    input  logic            reset,
    mech_drive_sum_if.slave bus
);
    localparam int N_CYCLES = n_cycles_of(n_mech_modes);
    localparam int CNT_W    = (clog2(N_CYCLES) < 1) ? 1 : clog2(N_CYCLES);
    localparam int CW       = dw + clog2(n_cav) + 1;
    localparam int FW       = CW + 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(N_CYCLES - 1);

    logic [CNT_W-1:0] mech_cnt_reg;
    logic             start_reg;
    logic             start_eig_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            mech_cnt_reg  <= '0;
            start_reg     <= 1'b0;
            start_eig_reg <= 1'b0;
        end else begin
            mech_cnt_reg  <= (mech_cnt_reg == '0) ? CNT_TOP : mech_cnt_reg - 1'b1;
            start_reg     <= (mech_cnt_reg == '0);
            start_eig_reg <= start_reg;
        end
    end

    logic [ew-1:0] environment;

    mech_noise_cic #(
        .noise_bits (noise_bits),
        .ew         (ew)
    ) u_noise (
        .clk         (clk),
        .reset       (reset),
        .rnd         (bus.rnd),
        .start_eig   (start_eig_reg),
        .environment (environment)
    );

    logic signed [CW-1:0] cav_ext [n_cav];
    logic signed [CW-1:0] cav_total;

    for (genvar gi = 0; gi < n_cav; gi++) begin : g_cav
        assign cav_ext[gi] = CW'($signed(bus.cav_eig_drive[gi*dw +: dw]));
    end

    always_comb begin
        cav_total = '0;
        for (int k = 0; k < n_cav; k++) begin
            cav_total = cav_total + cav_ext[k];
        end
    end

    logic signed [CW-1:0] cav_sum_reg;
    logic signed [dw:0]   local_reg;
    logic signed [FW-1:0] full;
    logic signed [dw-1:0] eig_drive0_reg;
    logic signed [dw-1:0] eig_drive_reg;
    logic                 edrive_clip_reg;

    // One guard bit above the wider operand keeps the full sum exact.
    assign full = FW'(cav_sum_reg) + FW'(local_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            cav_sum_reg     <= '0;
            local_reg       <= '0;
            eig_drive0_reg  <= '0;
            edrive_clip_reg <= 1'b0;
            eig_drive_reg   <= '0;
        end else begin
            cav_sum_reg     <= cav_total;
            local_reg       <= $signed({bus.piezo_eig_drive[dw-1], bus.piezo_eig_drive})
                             + $signed({bus.noise_eig_drive[dw-1], bus.noise_eig_drive});
            eig_drive0_reg  <= dw'(sat64(64'(full), dw));
            edrive_clip_reg <= clipped64(64'(full), dw);
            eig_drive_reg   <= eig_drive0_reg;
        end
    end

    logic        clip_sticky_reg;
    logic [15:0] clip_count_reg;

    // A clip event in the same cycle as a clear wins and counts as the first event.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_sticky_reg <= 1'b0;
            clip_count_reg  <= '0;
        end else if (edrive_clip_reg) begin
            clip_sticky_reg <= 1'b1;
            if (bus.clip_clear)
                clip_count_reg <= 16'd1;
            else if (clip_count_reg != 16'hFFFF)
                clip_count_reg <= clip_count_reg + 16'd1;
        end else if (bus.clip_clear) begin
            clip_sticky_reg <= 1'b0;
            clip_count_reg  <= '0;
        end
    end

    assign bus.start       = start_reg;
    assign bus.start_outer = start_reg;
    assign bus.start_eig   = start_eig_reg;
    assign bus.environment = environment;
    assign bus.eig_drive   = eig_drive_reg;
    assign bus.edrive_clip = edrive_clip_reg;
    assign bus.clip_sticky = clip_sticky_reg;
    assign bus.clip_count  = clip_count_reg;
endmodule
